// File: rtl/ddu_link_framer.sv
// Link framer: buffers controller event words in an elastic FIFO and wraps each
// event as SOP / data / CRC-16 / EOP / EXT with idle fill for the 8b/10b transmitter.
module ddu_link_framer #(
  parameter int FIFO_AW   = 4,
  parameter int AFULL_LVL = 12,
  parameter int IFG       = 2
) (
  input  logic        CLKDDU,
  input  logic        RST,
  input  logic        GIGAEN,
  input  logic [15:0] DIN,
  input  logic        DIN_VALID,
  input  logic        DIN_LAST,
  output logic        AFULL,
  output logic        OVFL,
  output logic [15:0] TXD,
  output logic [1:0]  TXK,
  output logic        FRAME_ACT,
  output logic [15:0] FRAME_CNT
);

  localparam int                 DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   DEPTH_C  = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   AFULL_C  = (FIFO_AW+1)'(AFULL_LVL);
  localparam logic [FIFO_AW:0]   ONE_C    = (FIFO_AW+1)'(1);
  localparam logic [3:0]         IFG_C    = 4'(IFG);
  localparam logic [15:0]        W_IDLE   = 16'h50BC;
  localparam logic [15:0]        W_SOP    = 16'hF7FB;
  localparam logic [15:0]        W_EOP    = 16'hFDFE;
  localparam logic [15:0]        W_EXT    = 16'hF7F7;

  typedef enum logic [2:0] {ST_IDLE, ST_DATA, ST_CRC, ST_EOP, ST_EXT} state_t;

  state_t               state_reg;
  logic [16:0]          mem [0:DEPTH-1];
  logic [FIFO_AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_AW:0]     count_reg, count_next;
  logic [FIFO_AW:0]     pend_reg, pend_next;
  logic [15:0]          crc_reg;
  logic [3:0]           ifg_reg;

  logic        fifo_full, fifo_empty, flush, pop, wr_en, drop, start_frame;
  logic [16:0] rd_word;
  logic [15:0] crc_stage [0:16];

  assign fifo_full   = (count_reg == DEPTH_C);
  assign fifo_empty  = (count_reg == '0);
  assign flush       = (state_reg == ST_IDLE) && !GIGAEN;
  assign pop         = (state_reg == ST_DATA) && !fifo_empty;
  assign rd_word     = mem[rd_ptr_reg];
  // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
  assign wr_en       = DIN_VALID && !flush && (!fifo_full || pop);
  assign drop        = DIN_VALID && !flush && fifo_full && !pop;
  assign start_frame = GIGAEN && (ifg_reg >= IFG_C) && ((pend_reg != '0) || fifo_full);

  // CRC-16-CCITT over one whole word, MSB first, unrolled into 16 shift stages.
  assign crc_stage[0] = crc_reg ^ rd_word[15:0];
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_crc
      assign crc_stage[gi+1] = crc_stage[gi][15] ? ({crc_stage[gi][14:0], 1'b0} ^ 16'h1021)
                                                 :  {crc_stage[gi][14:0], 1'b0};
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    if (flush)
      count_next = '0;
    else if (wr_en && !pop)
      count_next = count_reg + ONE_C;
    else if (!wr_en && pop)
      count_next = count_reg - ONE_C;
  end

  always_comb begin
    pend_next = pend_reg;
    if (flush)
      pend_next = '0;
    else if ((wr_en && DIN_LAST) && !(pop && rd_word[16]))
      pend_next = pend_reg + ONE_C;
    else if (!(wr_en && DIN_LAST) && (pop && rd_word[16]))
      pend_next = pend_reg - ONE_C;
  end

  always_ff @(posedge CLKDDU) begin
    if (wr_en)
      mem[wr_ptr_reg] <= {DIN_LAST, DIN};
  end

  always_ff @(posedge CLKDDU) begin
    if (RST) begin
      state_reg  <= ST_IDLE;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      pend_reg   <= '0;
      crc_reg    <= 16'hFFFF;
      ifg_reg    <= 4'hF;
      TXD        <= W_IDLE;
      TXK        <= 2'b01;
      FRAME_ACT  <= 1'b0;
      FRAME_CNT  <= 16'h0000;
      AFULL      <= 1'b0;
      OVFL       <= 1'b0;
    end else begin
      count_reg <= count_next;
      pend_reg  <= pend_next;
      AFULL     <= (count_next >= AFULL_C);
      if (drop)
        OVFL <= 1'b1;
      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end

      // Each state names the word driven at this edge; TXD/TXK/FRAME_ACT follow it.
      case (state_reg)
        ST_IDLE: begin
          if (start_frame) begin
            TXD       <= W_SOP;
            TXK       <= 2'b11;
            FRAME_ACT <= 1'b1;
            crc_reg   <= 16'hFFFF;
            state_reg <= ST_DATA;
          end else begin
            TXD       <= W_IDLE;
            TXK       <= 2'b01;
            FRAME_ACT <= 1'b0;
            if (ifg_reg != 4'hF)
              ifg_reg <= ifg_reg + 4'd1;
          end
        end
        ST_DATA: begin
          if (pop) begin
            TXD     <= rd_word[15:0];
            TXK     <= 2'b00;
            crc_reg <= crc_stage[16];
            if (rd_word[16])
              state_reg <= ST_CRC;
          end else begin
            TXD <= W_EXT;
            TXK <= 2'b11;
          end
        end
        ST_CRC: begin
          TXD       <= crc_reg;
          TXK       <= 2'b00;
          state_reg <= ST_EOP;
        end
        ST_EOP: begin
          TXD       <= W_EOP;
          TXK       <= 2'b11;
          FRAME_CNT <= FRAME_CNT + 16'd1;
          state_reg <= ST_EXT;
        end
        ST_EXT: begin
          TXD       <= W_EXT;
          TXK       <= 2'b11;
          ifg_reg   <= 4'h0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddu_link_framer.sv
// Directed bench for ddu_link_framer: vector table for frame sequencing plus a
// hand-written fill/overflow/underrun sequence.
module tb_ddu_link_framer;

  logic        CLKDDU = 1'b0;
  logic        RST, GIGAEN, DIN_VALID, DIN_LAST;
  logic [15:0] DIN;
  logic        AFULL, OVFL, FRAME_ACT;
  logic [15:0] TXD, FRAME_CNT;
  logic [1:0]  TXK;

  int total = 0;
  int bad   = 0;

  ddu_link_framer #(.FIFO_AW(4), .AFULL_LVL(12), .IFG(2)) dut (
    .CLKDDU(CLKDDU), .RST(RST), .GIGAEN(GIGAEN), .DIN(DIN),
    .DIN_VALID(DIN_VALID), .DIN_LAST(DIN_LAST), .AFULL(AFULL), .OVFL(OVFL),
    .TXD(TXD), .TXK(TXK), .FRAME_ACT(FRAME_ACT), .FRAME_CNT(FRAME_CNT)
  );

  always #5 CLKDDU = ~CLKDDU;

  typedef struct {
    logic        rst, gig, vld, lst;
    logic [15:0] din;
    logic [15:0] e_txd;
    logic [1:0]  e_txk;
    logic        e_act;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  // Reference CRC, bit-serial: feedback is the outgoing MSB xor the incoming data bit.
  function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic g, input logic vl, input logic ls,
                     input logic [15:0] d, input logic [15:0] t, input logic [1:0] k,
                     input logic a, input logic [15:0] c);
    vec_t v;
    v.rst = r; v.gig = g; v.vld = vl; v.lst = ls; v.din = d;
    v.e_txd = t; v.e_txk = k; v.e_act = a; v.e_cnt = c;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge CLKDDU);
    #1;
  endtask

  initial begin
    logic [15:0] crc_a, crc_b, crc_exp, exp_txd, w;
    logic [1:0]  exp_txk;
    int          exp_occ;

    RST = 1'b1; GIGAEN = 1'b1; DIN = 16'h0; DIN_VALID = 1'b0; DIN_LAST = 1'b0;
    crc_a = crc_ref(16'hFFFF, 16'h1234);
    crc_b = crc_ref(16'hFFFF, 16'hABCD);

    // reset, 3 cycles
    for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 16'h0, 16'h50BC, 2'b01, 0, 16'd0);
    // single-word frame, word 0000
    add(0, 1, 1, 1, 16'h0000, 16'h50BC, 2'b01, 0, 16'd0);
    add(0, 1, 0, 0, 16'h0000, 16'hF7FB, 2'b11, 1, 16'd0);
    add(0, 1, 0, 0, 16'h0000, 16'h0000, 2'b00, 1, 16'd0);
    add(0, 1, 0, 0, 16'h0000, 16'h1D0F, 2'b00, 1, 16'd0);
    add(0, 1, 0, 0, 16'h0000, 16'hFDFE, 2'b11, 1, 16'd1);
    add(0, 1, 0, 0, 16'h0000, 16'hF7F7, 2'b11, 1, 16'd1);
    add(0, 1, 0, 0, 16'h0000, 16'h50BC, 2'b01, 0, 16'd1);
    add(1, 1, 0, 0, 16'h0000, 16'h50BC, 2'b01, 0, 16'd0);
    // back-to-back one-word frames, IFG = 2
    add(0, 1, 1, 1, 16'h1234, 16'h50BC, 2'b01, 0, 16'd0);
    add(0, 1, 1, 1, 16'hABCD, 16'hF7FB, 2'b11, 1, 16'd0);
    add(0, 1, 0, 0, 16'h0000, 16'h1234, 2'b00, 1, 16'd0);
    add(0, 1, 0, 0, 16'h0000, crc_a,    2'b00, 1, 16'd0);
    add(0, 1, 0, 0, 16'h0000, 16'hFDFE, 2'b11, 1, 16'd1);
    add(0, 1, 0, 0, 16'h0000, 16'hF7F7, 2'b11, 1, 16'd1);
    add(0, 1, 0, 0, 16'h0000, 16'h50BC, 2'b01, 0, 16'd1);
    add(0, 1, 0, 0, 16'h0000, 16'h50BC, 2'b01, 0, 16'd1);
    add(0, 1, 0, 0, 16'h0000, 16'hF7FB, 2'b11, 1, 16'd1);
    add(0, 1, 0, 0, 16'h0000, 16'hABCD, 2'b00, 1, 16'd1);
    add(0, 1, 0, 0, 16'h0000, crc_b,    2'b00, 1, 16'd1);
    add(0, 1, 0, 0, 16'h0000, 16'hFDFE, 2'b11, 1, 16'd2);
    add(0, 1, 0, 0, 16'h0000, 16'hF7F7, 2'b11, 1, 16'd2);
    add(0, 1, 0, 0, 16'h0000, 16'h50BC, 2'b01, 0, 16'd2);
    // GIGAEN low in IDLE: 2-word event is discarded, nothing left to send later
    add(0, 0, 1, 0, 16'h5555, 16'h50BC, 2'b01, 0, 16'd2);
    add(0, 0, 1, 1, 16'h6666, 16'h50BC, 2'b01, 0, 16'd2);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 16'h0, 16'h50BC, 2'b01, 0, 16'd2);
    // GIGAEN dropped after SOP: the frame still completes, then idles only
    add(0, 1, 1, 1, 16'h0000, 16'h50BC, 2'b01, 0, 16'd2);
    add(0, 1, 0, 0, 16'h0000, 16'hF7FB, 2'b11, 1, 16'd2);
    add(0, 0, 0, 0, 16'h0000, 16'h0000, 2'b00, 1, 16'd2);
    add(0, 0, 0, 0, 16'h0000, 16'h1D0F, 2'b00, 1, 16'd2);
    add(0, 0, 0, 0, 16'h0000, 16'hFDFE, 2'b11, 1, 16'd3);
    add(0, 0, 0, 0, 16'h0000, 16'hF7F7, 2'b11, 1, 16'd3);
    add(0, 0, 0, 0, 16'h0000, 16'h50BC, 2'b01, 0, 16'd3);
    add(0, 0, 1, 1, 16'h7777, 16'h50BC, 2'b01, 0, 16'd3);
    add(0, 1, 0, 0, 16'h0000, 16'h50BC, 2'b01, 0, 16'd3);
    add(0, 1, 0, 0, 16'h0000, 16'h50BC, 2'b01, 0, 16'd3);

    foreach (vecs[i]) begin
      RST = vecs[i].rst; GIGAEN = vecs[i].gig; DIN_VALID = vecs[i].vld;
      DIN_LAST = vecs[i].lst; DIN = vecs[i].din;
      tick();
      $display("vec %0d: txd=%h txk=%b act=%b cnt=%0d", i, TXD, TXK, FRAME_ACT, FRAME_CNT);
      chk($sformatf("v%0d_txd", i), 32'(TXD), 32'(vecs[i].e_txd));
      chk($sformatf("v%0d_txk", i), 32'(TXK), 32'(vecs[i].e_txk));
      chk($sformatf("v%0d_act", i), 32'(FRAME_ACT), 32'(vecs[i].e_act));
      chk($sformatf("v%0d_cnt", i), 32'(FRAME_CNT), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d_afull", i), 32'(AFULL), 32'(0));
      chk($sformatf("v%0d_ovfl", i), 32'(OVFL), 32'(0));
    end

    // Fill to full with no LAST (frame starts on full, 17th word dropped),
    // drain into underrun filler, then close with a late LAST word.
    RST = 1'b1; GIGAEN = 1'b1; DIN_VALID = 1'b0; DIN_LAST = 1'b0;
    tick();
    RST = 1'b0;
    crc_exp = 16'hFFFF;
    for (int n = 1; n <= 43; n++) begin
      DIN_VALID = (n <= 20) || (n == 38);
      DIN_LAST  = (n == 38);
      DIN       = (n == 38) ? 16'hBEEF : 16'h0100 + 16'(n - 1);
      tick();
      w = 16'h0;
      if (n <= 16)                 begin exp_txd = 16'h50BC; exp_txk = 2'b01; end
      else if (n == 17)            begin exp_txd = 16'hF7FB; exp_txk = 2'b11; end
      else if (n <= 33)            begin w = 16'h0100 + 16'(n - 18); exp_txd = w; exp_txk = 2'b00; end
      else if (n <= 36)            begin w = 16'h0100 + 16'(n - 17); exp_txd = w; exp_txk = 2'b00; end
      else if (n <= 38)            begin exp_txd = 16'hF7F7; exp_txk = 2'b11; end
      else if (n == 39)            begin w = 16'hBEEF; exp_txd = w; exp_txk = 2'b00; end
      else if (n == 40)            begin exp_txd = crc_exp; exp_txk = 2'b00; end
      else if (n == 41)            begin exp_txd = 16'hFDFE; exp_txk = 2'b11; end
      else if (n == 42)            begin exp_txd = 16'hF7F7; exp_txk = 2'b11; end
      else                         begin exp_txd = 16'h50BC; exp_txk = 2'b01; end
      if ((n >= 18 && n <= 36) || n == 39) crc_exp = crc_ref(crc_exp, w);
      if (n <= 16)      exp_occ = n;
      else if (n <= 20) exp_occ = 16;
      else if (n <= 36) exp_occ = 36 - n;
      else if (n == 38) exp_occ = 1;
      else              exp_occ = 0;
      $display("ovf %0d: txd=%h txk=%b afull=%b ovfl=%b", n, TXD, TXK, AFULL, OVFL);
      chk($sformatf("o%0d_txd", n), 32'(TXD), 32'(exp_txd));
      chk($sformatf("o%0d_txk", n), 32'(TXK), 32'(exp_txk));
      chk($sformatf("o%0d_afull", n), 32'(AFULL), 32'(exp_occ >= 12));
      chk($sformatf("o%0d_ovfl", n), 32'(OVFL), 32'(n >= 17));
    end
    chk("ovf_frame_cnt", 32'(FRAME_CNT), 32'(1));

    DIN_VALID = 1'b0; DIN_LAST = 1'b0; RST = 1'b1;
    tick();
    RST = 1'b0;
    $display("rst: txd=%h ovfl=%b afull=%b cnt=%0d", TXD, OVFL, AFULL, FRAME_CNT);
    chk("rst_ovfl", 32'(OVFL), 32'(0));
    chk("rst_afull", 32'(AFULL), 32'(0));
    chk("rst_txd", 32'(TXD), 32'(16'h50BC));
    chk("rst_cnt", 32'(FRAME_CNT), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
